// File: rtl/ioctl_upload_server.sv
// ioctl_upload_server: serves HPS ioctl upload reads for one ioctl_index by
// fetching bytes from a core-side byte RAM through an arbitrated read port.
// Each requested byte is returned on ioctl_din; ioctl_wait stalls the HPS
// until it is valid. Addresses at or beyond LEN read back as 8'hFF.
//
// Optional build macro UPLOAD_CHECKSUM_EN: when defined, the bytes served in
// a session are summed modulo 256. A read of address LEN then returns the
// two's complement of that sum in one cycle, without touching the RAM.
module ioctl_upload_server #(
  parameter logic [7:0] INDEX  = 8'd4,
  parameter int         ADDR_W = 10,
  parameter int         LEN    = 1024,
  parameter int         RD_LAT = 2
) (
  input  logic              clk_sys,
  input  logic              RESET_n,
  input  logic              ioctl_upload,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_wait,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic              mem_grant,
  input  logic [7:0]        mem_q,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    LAT  = 2'd2,
    CAP  = 2'd3
  } state_t;

  // Full 25-bit compare: upper address bits never alias into the buffer.
  localparam logic [24:0] LEN_ADDR = 25'(LEN);
  // The grant cycle itself counts as one latency cycle.
  localparam logic [2:0]  LAT_LOAD = 3'(RD_LAT - 1);

  state_t            state_reg, state_next;
  logic [2:0]        lat_cnt_reg, lat_cnt_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic              mem_rd_reg, mem_rd_next;
  logic              wait_reg, wait_next;
  logic [7:0]        din_reg, din_next;
  logic              served_reg, served_next;
  logic              done_reg, done_next;
  logic              active_prev_reg;

  logic session_active;
  logic session_start;
  logic session_end;

`ifdef UPLOAD_CHECKSUM_EN
  logic [7:0] csum_reg, csum_next;
  logic [7:0] csum_base;
`endif

  assign session_active = ioctl_upload && (ioctl_index == INDEX);
  assign session_start  = session_active && !active_prev_reg;
  assign session_end    = !session_active && active_prev_reg;

`ifdef UPLOAD_CHECKSUM_EN
  // A new session starts its sum from zero, even if a byte is checked the same cycle.
  assign csum_base = session_start ? 8'd0 : csum_reg;
`endif

  // State register and all registered outputs; reset clears everything at once.
  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) begin
      state_reg       <= IDLE;
      lat_cnt_reg     <= 3'd0;
      mem_addr_reg    <= '0;
      mem_rd_reg      <= 1'b0;
      wait_reg        <= 1'b0;
      din_reg         <= 8'd0;
      served_reg      <= 1'b0;
      done_reg        <= 1'b0;
      active_prev_reg <= 1'b0;
`ifdef UPLOAD_CHECKSUM_EN
      csum_reg        <= 8'd0;
`endif
    end else begin
      state_reg       <= state_next;
      lat_cnt_reg     <= lat_cnt_next;
      mem_addr_reg    <= mem_addr_next;
      mem_rd_reg      <= mem_rd_next;
      wait_reg        <= wait_next;
      din_reg         <= din_next;
      served_reg      <= served_next;
      done_reg        <= done_next;
      active_prev_reg <= session_active;
`ifdef UPLOAD_CHECKSUM_EN
      csum_reg        <= csum_next;
`endif
    end
  end

  // Next-state and next-output logic; a lost session overrides every state.
  always_comb begin
    state_next    = state_reg;
    lat_cnt_next  = lat_cnt_reg;
    mem_addr_next = mem_addr_reg;
    mem_rd_next   = mem_rd_reg;
    wait_next     = wait_reg;
    din_next      = din_reg;
    served_next   = served_reg;
    done_next     = 1'b0;
`ifdef UPLOAD_CHECKSUM_EN
    csum_next     = csum_reg;
`endif

    if (!session_active) begin
      // Abort: drop any pending request, release the HPS, keep the last byte.
      state_next  = IDLE;
      mem_rd_next = 1'b0;
      wait_next   = 1'b0;
      if (session_end) begin
        done_next   = served_reg;
        served_next = 1'b0;
      end
    end else begin
      if (session_start) begin
        served_next = 1'b0;
`ifdef UPLOAD_CHECKSUM_EN
        csum_next   = 8'd0;
`endif
      end

      case (state_reg)
        IDLE: begin
          if (ioctl_rd) begin
            if (ioctl_addr < LEN_ADDR) begin
              mem_addr_next = ioctl_addr[ADDR_W-1:0];
              mem_rd_next   = 1'b1;
              wait_next     = 1'b1;
              state_next    = REQ;
            end
`ifdef UPLOAD_CHECKSUM_EN
            else if (ioctl_addr == LEN_ADDR) begin
              din_next = ~csum_base + 8'd1;
            end
`endif
            else begin
              din_next = 8'hFF;
            end
          end
        end

        REQ: begin
          if (mem_grant) begin
            mem_rd_next  = 1'b0;
            lat_cnt_next = LAT_LOAD;
            state_next   = LAT;
          end
        end

        LAT: begin
          if (lat_cnt_reg == 3'd0) begin
            state_next = CAP;
          end else begin
            lat_cnt_next = lat_cnt_reg - 3'd1;
          end
        end

        CAP: begin
          din_next    = mem_q;
          wait_next   = 1'b0;
          served_next = 1'b1;
`ifdef UPLOAD_CHECKSUM_EN
          csum_next   = csum_base + mem_q;
`endif
          state_next  = IDLE;
        end

        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  assign ioctl_din  = din_reg;
  assign ioctl_wait = wait_reg;
  assign mem_addr   = mem_addr_reg;
  assign mem_rd     = mem_rd_reg;
  assign busy       = (state_reg != IDLE);
  assign done       = done_reg;

endmodule

// File: tb/tb_ioctl_upload_server.sv
// Testbench for ioctl_upload_server: byte RAM with fixed read latency behind a
// controllable arbiter, and a session-level model of the expected bytes.
module tb_ioctl_upload_server;

  localparam logic [7:0] INDEX  = 8'd4;
  localparam int         ADDR_W = 10;
  localparam int         LEN    = 1024;
  localparam int         RD_LAT = 2;
`ifdef UPLOAD_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic              clk_sys;
  logic              RESET_n;
  logic              ioctl_upload;
  logic [7:0]        ioctl_index;
  logic              ioctl_rd;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_din;
  logic              ioctl_wait;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_grant;
  logic [7:0]        mem_q;
  logic              busy;
  logic              done;

  logic       grant_en;
  int         grant_mode;   // 0: grant_en left as set by the test, 1: random per cycle
  logic [7:0] ram  [0:LEN-1];
  logic [7:0] pipe [0:RD_LAT-1];

  int checks = 0;
  int errors = 0;
  int model_sum;            // sum of bytes served in the current session
  bit model_served;

  ioctl_upload_server #(
    .INDEX (INDEX),
    .ADDR_W(ADDR_W),
    .LEN   (LEN),
    .RD_LAT(RD_LAT)
  ) dut (
    .clk_sys     (clk_sys),
    .RESET_n     (RESET_n),
    .ioctl_upload(ioctl_upload),
    .ioctl_index (ioctl_index),
    .ioctl_rd    (ioctl_rd),
    .ioctl_addr  (ioctl_addr),
    .ioctl_din   (ioctl_din),
    .ioctl_wait  (ioctl_wait),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_grant   (mem_grant),
    .mem_q       (mem_q),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk_sys = ~clk_sys;

  assign mem_grant = grant_en & mem_rd;

  // RAM: data for a granted read appears RD_LAT cycles later and then holds.
  always @(posedge clk_sys) begin
    if (mem_rd && mem_grant) pipe[0] <= ram[mem_addr];
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_q = pipe[RD_LAT-1];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] len_expect(input int s);
    return CSUM_EN ? 8'((256 - (s % 256)) % 256) : 8'hFF;
  endfunction

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic start_session();
    ioctl_upload = 1'b1;
    ioctl_index  = INDEX;
    tick();
    model_sum    = 0;
    model_served = 1'b0;
  endtask

  // Pulse ioctl_rd for one cycle, then follow until ioctl_wait drops.
  // lat = clock edges after the edge that sampled ioctl_rd.
  task automatic do_read(input logic [24:0] a, output logic [7:0] got, output int lat,
                         output int rd_cycles, output bit addr_bad, output bit to);
    logic [9:0] a_lo;
    a_lo       = a[9:0];
    ioctl_addr = a;
    ioctl_rd   = 1'b1;
    tick();
    ioctl_rd   = 1'b0;
    lat = 0; rd_cycles = 0; addr_bad = 1'b0; to = 1'b0;
    while (1) begin
      if (mem_rd === 1'b1) begin
        rd_cycles++;
        if (mem_addr !== a_lo) addr_bad = 1'b1;
      end
      if (ioctl_wait !== 1'b1) break;
      if (lat >= 200) begin to = 1'b1; break; end
      if (grant_mode == 1) grant_en = 1'($urandom_range(0, 1));
      tick();
      lat++;
    end
    got = ioctl_din;
  endtask

  task automatic test_reset();
    RESET_n = 1'b0;
    #3;
    checks++; if (ioctl_din !== 8'd0) begin errors++; $display("FAIL reset_din got=%h exp=00", ioctl_din); end
    checks++; if (ioctl_wait !== 1'b0) begin errors++; $display("FAIL reset_wait got=%b exp=0", ioctl_wait); end
    checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL reset_mem_rd got=%b exp=0", mem_rd); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    tick();
    tick();
    RESET_n = 1'b1;
    tick();
    $display("txn reset released");
  endtask

  task automatic test_basic();
    logic [7:0] got; int lat, rdc; bit ab, to;
    ram[5] = 8'hA7;
    grant_mode = 0; grant_en = 1'b1;
    // Read strobe coincides with the session start.
    ioctl_upload = 1'b1; ioctl_index = INDEX;
    model_sum = 0; model_served = 1'b0;
    do_read(25'd5, got, lat, rdc, ab, to);
    model_sum += 8'hA7; model_served = 1'b1;
    $display("txn basic addr=5 din=%h lat=%0d rd_cycles=%0d", got, lat, rdc);
    checks++; if (to) begin errors++; $display("FAIL basic_timeout lat=%0d exp=%0d", lat, RD_LAT + 2); end
    checks++; if (got !== 8'hA7) begin errors++; $display("FAIL basic_din got=%h exp=a7", got); end
    checks++; if (lat != RD_LAT + 2) begin errors++; $display("FAIL basic_latency got=%0d exp=%0d", lat, RD_LAT + 2); end
    checks++; if (rdc != 1) begin errors++; $display("FAIL basic_mem_rd_cycles got=%0d exp=1", rdc); end
    checks++; if (ab) begin errors++; $display("FAIL basic_mem_addr got=bad exp=5"); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got=%b exp=0", busy); end
    ioctl_upload = 1'b0;
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL basic_done_pulse got=%b exp=1", done); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_single got=%b exp=0", done); end
  endtask

  task automatic test_grant_holdoff();
    int n; bit held_bad;
    ram[7] = 8'h5C; ram[20] = 8'h33;
    start_session();
    grant_mode = 0; grant_en = 1'b0;
    ioctl_addr = 25'd7; ioctl_rd = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    held_bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (mem_rd !== 1'b1 || ioctl_wait !== 1'b1 || mem_addr !== 10'd7) held_bad = 1'b1;
      // A strobe while busy must be ignored.
      if (i == 3) begin ioctl_addr = 25'd20; ioctl_rd = 1'b1; end
      else ioctl_rd = 1'b0;
      if (i < 9) tick();
    end
    checks++; if (held_bad) begin errors++; $display("FAIL holdoff_held got=dropped exp=mem_rd,wait,addr7 held"); end
    grant_en = 1'b1;
    tick();          // grant edge
    n = 0;
    while (ioctl_wait === 1'b1 && n < 50) begin tick(); n++; end
    model_sum += 8'h5C; model_served = 1'b1;
    $display("txn holdoff addr=7 din=%h cycles_after_grant=%0d", ioctl_din, n);
    checks++; if (n != RD_LAT + 1) begin errors++; $display("FAIL holdoff_latency got=%0d exp=%0d", n, RD_LAT + 1); end
    checks++; if (ioctl_din !== 8'h5C) begin errors++; $display("FAIL holdoff_din got=%h exp=5c", ioctl_din); end
    ioctl_upload = 1'b0; tick(); tick();
  endtask

  task automatic test_out_of_range();
    logic [7:0] got; int lat, rdc; bit ab, to;
    logic [24:0] addrs [0:3];
    addrs[0] = 25'd1025; addrs[1] = 25'h1000400; addrs[2] = 25'h1FFFFFF; addrs[3] = 25'(LEN);
    start_session();
    grant_mode = 0; grant_en = 1'b1;
    ram[5] = 8'hA7;
    for (int k = 0; k < 4; k++) begin
      do_read(25'd5, got, lat, rdc, ab, to);   // ensure din is not FF beforehand
      model_sum += 8'hA7; model_served = 1'b1;
      do_read(addrs[k], got, lat, rdc, ab, to);
      $display("txn oor addr=%h din=%h lat=%0d rd_cycles=%0d", addrs[k], got, lat, rdc);
      checks++;
      if (got !== ((k == 3) ? len_expect(model_sum) : 8'hFF)) begin
        errors++; $display("FAIL oor_din addr=%h got=%h exp=%h", addrs[k], got, (k == 3) ? len_expect(model_sum) : 8'hFF);
      end
      checks++; if (lat != 0) begin errors++; $display("FAIL oor_wait addr=%h got=%0d exp=0", addrs[k], lat); end
      checks++; if (rdc != 0) begin errors++; $display("FAIL oor_mem_rd addr=%h got=%0d exp=0", addrs[k], rdc); end
    end
    ioctl_upload = 1'b0; tick(); tick();
  endtask

  task automatic test_wrong_index();
    logic [7:0] saved; bit bad;
    ioctl_upload = 1'b1; ioctl_index = 8'd3;
    tick();
    saved = ioctl_din; bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ioctl_addr = 25'($urandom_range(0, LEN - 1));
      ioctl_rd = 1'b1;
      tick();
      ioctl_rd = 1'b0;
      if (mem_rd !== 1'b0 || ioctl_wait !== 1'b0 || busy !== 1'b0) bad = 1'b1;
      tick();
      if (mem_rd !== 1'b0 || ioctl_wait !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    $display("txn wrong_index din=%h", ioctl_din);
    checks++; if (bad) begin errors++; $display("FAIL wrong_index_activity got=active exp=idle"); end
    checks++; if (ioctl_din !== saved) begin errors++; $display("FAIL wrong_index_din got=%h exp=%h", ioctl_din, saved); end
    ioctl_upload = 1'b0; ioctl_index = INDEX; tick(); tick();
  endtask

  task automatic test_abort();
    logic [7:0] got, saved; int lat, rdc; bit ab, to;
    ram[9] = 8'h9E; ram[10] = 8'h10; ram[11] = 8'h11;
    grant_mode = 0; grant_en = 1'b1;
    start_session();
    do_read(25'd9, got, lat, rdc, ab, to);
    saved = got;
    ioctl_addr = 25'd10; ioctl_rd = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    tick();          // granted, now waiting out the latency
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_in_lat_busy got=%b exp=1", busy); end
    ioctl_upload = 1'b0;
    tick();
    $display("txn abort served_before din=%h done=%b", ioctl_din, done);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (ioctl_wait !== 1'b0) begin errors++; $display("FAIL abort_wait got=%b exp=0", ioctl_wait); end
    checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL abort_mem_rd got=%b exp=0", mem_rd); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL abort_done got=%b exp=1", done); end
    checks++; if (ioctl_din !== saved) begin errors++; $display("FAIL abort_din_kept got=%h exp=%h", ioctl_din, saved); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done_single got=%b exp=0", done); end
    // Second session: aborted before any byte completes, so no done.
    start_session();
    ioctl_addr = 25'd11; ioctl_rd = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    tick();
    ioctl_upload = 1'b0;
    tick();
    $display("txn abort unserved done=%b", done);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_unserved_done got=%b exp=0", done); end
    checks++; if (ioctl_wait !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_unserved_idle got=wait%b,busy%b exp=0,0", ioctl_wait, busy); end
    tick();
  endtask

  task automatic test_reset_midfetch();
    logic [7:0] got; int lat, rdc; bit ab, to;
    ram[12] = 8'hC3;
    grant_mode = 0; grant_en = 1'b1;
    start_session();
    do_read(25'd12, got, lat, rdc, ab, to);   // leaves a nonzero din
    grant_en = 1'b0;
    ioctl_addr = 25'd12; ioctl_rd = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    checks++; if (mem_rd !== 1'b1) begin errors++; $display("FAIL midfetch_in_req got=%b exp=1", mem_rd); end
    #2;
    RESET_n = 1'b0;
    #1;
    $display("txn reset_midfetch din=%h wait=%b mem_rd=%b", ioctl_din, ioctl_wait, mem_rd);
    checks++;
    if (ioctl_din !== 8'd0 || ioctl_wait !== 1'b0 || mem_addr !== '0 || mem_rd !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL midfetch_async_clear got=din%h,wait%b,addr%h,rd%b,busy%b,done%b exp=all0",
               ioctl_din, ioctl_wait, mem_addr, mem_rd, busy, done);
    end
    #1;
    RESET_n = 1'b1;
    grant_en = 1'b1;
    tick();
    checks++; if (mem_rd !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midfetch_dropped got=rd%b,busy%b exp=0,0", mem_rd, busy); end
    ioctl_upload = 1'b0; tick(); tick();
  endtask

  task automatic test_checksum();
    logic [7:0] got; int lat, rdc; bit ab, to; int bad_cnt;
    grant_mode = 0; grant_en = 1'b1;
    for (int i = 0; i < LEN; i++) ram[i] = 8'h01;
    start_session();
    bad_cnt = 0;
    for (int i = 0; i < LEN; i++) begin
      do_read(25'(i), got, lat, rdc, ab, to);
      if (to || got !== 8'h01) bad_cnt++;
      model_sum += 1;
    end
    checks++; if (bad_cnt != 0) begin errors++; $display("FAIL csum_sweep got=%0d bad reads exp=0", bad_cnt); end
    do_read(25'(LEN), got, lat, rdc, ab, to);
    $display("txn csum sweep sum=%0d din=%h lat=%0d", model_sum, got, lat);
    checks++; if (got !== len_expect(model_sum)) begin errors++; $display("FAIL csum_all_ones got=%h exp=%h", got, len_expect(model_sum)); end
    checks++; if (lat != 0 || rdc != 0) begin errors++; $display("FAIL csum_no_access got=lat%0d,rd%0d exp=0,0", lat, rdc); end
    ioctl_upload = 1'b0; tick(); tick();
    for (int i = 0; i < LEN; i++) ram[i] = 8'h00;
    ram[0] = 8'h03;
    start_session();
    do_read(25'd0, got, lat, rdc, ab, to);
    model_sum += 3;
    do_read(25'd1, got, lat, rdc, ab, to);
    do_read(25'(LEN), got, lat, rdc, ab, to);
    $display("txn csum byte0 sum=%0d din=%h", model_sum, got);
    checks++; if (got !== len_expect(model_sum)) begin errors++; $display("FAIL csum_byte0 got=%h exp=%h", got, len_expect(model_sum)); end
    ioctl_upload = 1'b0; tick(); tick();
  endtask

  task automatic test_random();
    logic [7:0] got, exp_b; int lat, rdc, r; bit ab, to;
    logic [24:0] a;
    for (int i = 0; i < LEN; i++) ram[i] = 8'($urandom);
    grant_mode = 1;
    start_session();
    for (int t = 0; t < 80; t++) begin
      if ($urandom_range(0, 19) == 0) begin
        ioctl_upload = 1'b0;
        tick();
        checks++; if (done !== model_served) begin errors++; $display("FAIL rand_done got=%b exp=%b", done, model_served); end
        tick();
        start_session();
      end
      r = $urandom_range(0, 9);
      if (r < 7)       a = 25'($urandom_range(0, LEN - 1));
      else if (r == 7) a = 25'(LEN);
      else             a = 25'($urandom_range(LEN + 1, 32'h1FFFFFF));
      do_read(a, got, lat, rdc, ab, to);
      if (a < 25'(LEN)) exp_b = ram[a[9:0]];
      else if (a == 25'(LEN)) exp_b = len_expect(model_sum);
      else exp_b = 8'hFF;
      $display("txn rand addr=%h din=%h exp=%h lat=%0d", a, got, exp_b, lat);
      checks++; if (to) begin errors++; $display("FAIL rand_timeout addr=%h got=lat%0d exp=bounded", a, lat); end
      checks++; if (got !== exp_b) begin errors++; $display("FAIL rand_din addr=%h got=%h exp=%h", a, got, exp_b); end
      checks++;
      if (a < 25'(LEN) ? (lat < RD_LAT + 2 || rdc < 1 || ab) : (lat != 0 || rdc != 0)) begin
        errors++; $display("FAIL rand_timing addr=%h got=lat%0d,rd%0d,addrbad%b", a, lat, rdc, ab);
      end
      if (a < 25'(LEN)) begin
        model_sum += int'(exp_b);
        model_served = 1'b1;
      end
    end
    grant_mode = 0; grant_en = 1'b1;
    ioctl_upload = 1'b0; tick(); tick();
  endtask

  initial begin
    clk_sys = 1'b0; RESET_n = 1'b0;
    ioctl_upload = 1'b0; ioctl_index = 8'd0; ioctl_rd = 1'b0; ioctl_addr = '0;
    grant_en = 1'b1; grant_mode = 0;
    model_sum = 0; model_served = 1'b0;
    for (int i = 0; i < LEN; i++) ram[i] = 8'h00;
    test_reset();
    test_basic();
    test_grant_holdoff();
    test_out_of_range();
    test_wrong_index();
    test_abort();
    test_reset_midfetch();
    test_checksum();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
